ac3_accumulator: RTL and testbench

- Parametrised, registered third-stage accumulator for the DP engine.
- Sums a programmed number of partial-sum beats from the AC2 stage, on N_CH parallel channels, into per-channel accumulator registers.
- Presents the final sums through a valid/ready output.
- Adds what the combinational third-stage adder lacks: operand counting, input/output handshake, start/clear control, signed sign-extension, and selectable wrap or saturate with a sticky overflow flag.

---
 rtl/ac3_pkg.sv | 14 +
 rtl/ac3_lane.sv | 56 +++++
 rtl/ac3_accumulator.sv | 116 +++++++++++
 tb/tb_ac3_accumulator.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac3_pkg.sv
// rtl/ac3_pkg.sv - shared state type and width helpers for the AC3 accumulator
package ac3_pkg;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} ac3_state_t;

  function automatic int ac3_in_w(input int m, input int pa, input int pw);
    return $clog2(m) + pa + pw + 1;
  endfunction

  function automatic int ac3_acc_w(input int m, input int pa, input int pw, input int mno);
    return $clog2(m) + pa + pw + $clog2(mno) + 1;
  endfunction

endpackage

// File: rtl/ac3_lane.sv
// rtl/ac3_lane.sv - one accumulation channel: sign-extend, add, overflow detect, wrap or saturate
module ac3_lane #(
  parameter int IN_W  = 17,
  parameter int ACC_W = 26,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [IN_W-1:0]  i_data,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf
);

  // Wide enough for either operand plus a carry, even when the input is wider than the accumulator.
  localparam int SUM_W = ((IN_W > ACC_W) ? IN_W : ACC_W) + 1;

  logic [ACC_W-1:0]     r_acc;
  logic                 r_ovf;
  logic [SUM_W-1:0]     w_acc_x;
  logic [SUM_W-1:0]     w_in_x;
  logic [SUM_W-1:0]     w_sum;
  logic [SUM_W-ACC_W:0] w_top;
  logic                 w_ovf;
  logic [ACC_W-1:0]     w_next;

  assign w_acc_x = {{(SUM_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_in_x  = {{(SUM_W-IN_W){i_data[IN_W-1]}}, i_data};
  assign w_sum   = w_acc_x + w_in_x;

  // Result fits in ACC_W only if every bit above the new sign bit matches it.
  assign w_top = w_sum[SUM_W-1:ACC_W-1];
  assign w_ovf = !((&w_top) || !(|w_top));

  always_comb begin
    w_next = w_sum[ACC_W-1:0];
    if ((SAT != 0) && w_ovf) begin
      w_next = w_sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_acc <= w_next;
      r_ovf <= r_ovf | w_ovf;
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/ac3_accumulator.sv
// rtl/ac3_accumulator.sv - third-stage multi-channel accumulator with operand count and valid/ready handshake
module ac3_accumulator
  import ac3_pkg::*;
#(
  parameter int M     = 16,
  parameter int Pa    = 8,
  parameter int Pw    = 4,
  parameter int MNO   = 288,
  parameter int N_CH  = 4,
  parameter int IN_W  = ac3_in_w(M, Pa, Pw),
  parameter int ACC_W = ac3_acc_w(M, Pa, Pw, MNO),
  parameter int SAT   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(MNO+1)-1:0] num_ops,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*IN_W-1:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_CH*ACC_W-1:0]    out_data,
  output logic [N_CH-1:0]          out_ovf
);

  localparam int                NOPS_W = $clog2(MNO + 1);
  localparam logic [NOPS_W-1:0] MNO_V  = NOPS_W'(MNO);
  localparam logic [NOPS_W-1:0] ONE_V  = NOPS_W'(1);

  ac3_state_t        r_state;
  logic [NOPS_W-1:0] r_cnt;
  logic [NOPS_W-1:0] r_ops_q;
  logic              r_out_valid;
  logic              r_cfg_err;
  logic              w_ops_ok;
  logic              w_beat;
  logic              w_last;
  logic              w_clr;

  assign w_ops_ok = (num_ops != '0) && (num_ops <= MNO_V);
  assign in_ready = (r_state == ACC);
  assign w_beat   = in_valid && in_ready;
  assign w_last   = w_beat && (r_cnt == (r_ops_q - ONE_V));
  // Lanes clear on any accepted start, including the back-to-back start out of HOLD.
  assign w_clr    = start && w_ops_ok && ((r_state == IDLE) || ((r_state == HOLD) && out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ops_q     <= '0;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_ops_ok) begin
              r_ops_q <= num_ops;
              r_cnt   <= '0;
              r_state <= ACC;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ACC: begin
          if (w_beat) begin
            r_cnt <= r_cnt + ONE_V;
            if (w_last) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (start && w_ops_ok) begin
              r_ops_q <= num_ops;
              r_cnt   <= '0;
              r_state <= ACC;
            end else begin
              r_state   <= IDLE;
              r_cfg_err <= start;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign cfg_err   = r_cfg_err;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    ac3_lane #(
      .IN_W (IN_W),
      .ACC_W(ACC_W),
      .SAT  (SAT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_en  (w_beat),
      .i_data(in_data[c*IN_W +: IN_W]),
      .o_acc (out_data[c*ACC_W +: ACC_W]),
      .o_ovf (out_ovf[c])
    );
  end

endmodule

// File: tb/tb_ac3_accumulator.sv
// tb/tb_ac3_accumulator.sv - self-checking bench: default, 8-bit saturating and 8-bit wrapping instances
module tb_ac3_accumulator;

  localparam int N_CH = 4;
  localparam int IN_W = 17;
  localparam int AW0  = 26;
  localparam int AW8  = 8;
  localparam int NW   = 9;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [NW-1:0]          num_ops;
  logic                   in_valid;
  logic [N_CH*IN_W-1:0]   in_data;
  logic                   out_ready;

  logic                   cfg_err0, in_ready0, out_valid0;
  logic [N_CH*AW0-1:0]    od0;
  logic [N_CH-1:0]        ovf0;
  logic                   cfg_err1, in_ready1, out_valid1;
  logic [N_CH*AW8-1:0]    od1;
  logic [N_CH-1:0]        ovf1;
  logic                   cfg_err2, in_ready2, out_valid2;
  logic [N_CH*AW8-1:0]    od2;
  logic [N_CH-1:0]        ovf2;

  always #5 clk = ~clk;

  ac3_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .cfg_err(cfg_err0),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(od0), .out_ovf(ovf0)
  );

  ac3_accumulator #(.ACC_W(AW8), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .cfg_err(cfg_err1),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(od1), .out_ovf(ovf1)
  );

  ac3_accumulator #(.ACC_W(AW8), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .cfg_err(cfg_err2),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(od2), .out_ovf(ovf2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic signed [63:0] m_acc [3][N_CH];
  logic               m_ovf [3][N_CH];
  logic signed [63:0] beat  [N_CH];
  int                 m_w   [3] = '{AW0, AW8, AW8};
  bit                 m_sat [3] = '{1'b0, 1'b1, 1'b0};

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [63:0] get_d(input int i, input int c);
    case (i)
      0:       return 64'($signed(od0[c*AW0 +: AW0]));
      1:       return 64'($signed(od1[c*AW8 +: AW8]));
      default: return 64'($signed(od2[c*AW8 +: AW8]));
    endcase
  endfunction

  function automatic logic signed [63:0] get_o(input int i, input int c);
    case (i)
      0:       return {63'd0, ovf0[c]};
      1:       return {63'd0, ovf1[c]};
      default: return {63'd0, ovf2[c]};
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < N_CH; c++) begin
        m_acc[i][c] = 0;
        m_ovf[i][c] = 1'b0;
      end
  endtask

  // Exact integer sum, then folded into the instance's signed range by its overflow rule.
  task automatic model_add();
    logic signed [63:0] s, span, hi, lo, r;
    for (int i = 0; i < 3; i++) begin
      span = 64'sd1 <<< m_w[i];
      hi   = (span >>> 1) - 1;
      lo   = -(span >>> 1);
      for (int c = 0; c < N_CH; c++) begin
        s = m_acc[i][c] + beat[c];
        if (s > hi || s < lo) begin
          m_ovf[i][c] = 1'b1;
          if (m_sat[i]) r = (s > hi) ? hi : lo;
          else begin
            r = s % span;
            if (r < 0) r = r + span;
            if (r > hi) r = r - span;
          end
        end else begin
          r = s;
        end
        m_acc[i][c] = r;
      end
    end
  endtask

  task automatic pack_beat();
    logic signed [63:0] b;
    for (int c = 0; c < N_CH; c++) begin
      b = beat[c];
      in_data[c*IN_W +: IN_W] = b[IN_W-1:0];
    end
  endtask

  task automatic rand_beat();
    for (int c = 0; c < N_CH; c++)
      beat[c] = 64'($urandom_range(0, 131071)) - 64'sd65536;
    pack_beat();
  endtask

  task automatic set_beat(input int b0, input int b1, input int b2, input int b3);
    beat[0] = 64'(b0);
    beat[1] = 64'(b1);
    beat[2] = 64'(b2);
    beat[3] = 64'(b3);
    pack_beat();
  endtask

  task automatic send_beat();
    in_valid = 1'b1;
    check("beat_in_ready", {63'd0, in_ready0}, 1);
    tick();
    in_valid = 1'b0;
    model_add();
  endtask

  task automatic do_start(input int n);
    start   = 1'b1;
    num_ops = NW'(n);
    tick();
    start   = 1'b0;
    model_clear();
    check("start_in_ready", {63'd0, in_ready0}, 1);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < N_CH; c++) begin
        check($sformatf("%s_i%0d_c%0d_data", tag, i, c), get_d(i, c), m_acc[i][c]);
        check($sformatf("%s_i%0d_c%0d_ovf", tag, i, c), get_o(i, c), {63'd0, m_ovf[i][c]});
      end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_out_valid", {63'd0, out_valid0}, 0);
    check("release_in_ready", {63'd0, in_ready0}, 0);
  endtask

  initial begin
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int n, got, guard, v;

    rst = 1'b1; start = 1'b0; num_ops = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int c = 0; c < N_CH; c++) beat[c] = 0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid0}, 0);
    check("rst_in_ready", {63'd0, in_ready0}, 0);
    check("rst_cfg_err", {63'd0, cfg_err0}, 0);
    check("rst_out_data", {38'd0, od0[25:0]} | 64'(|od0), 0);
    check("rst_out_ovf", {60'd0, ovf0}, 0);

    // Basic three-beat sum with one-cycle output latency
    do_start(3);
    set_beat(100, -5, 0, 0); send_beat();
    check("b3_valid_early1", {63'd0, out_valid0}, 0);
    set_beat(200, -5, 0, 0); send_beat();
    check("b3_valid_early2", {63'd0, out_valid0}, 0);
    set_beat(300, -5, 0, 0); send_beat();
    check("b3_valid", {63'd0, out_valid0}, 1);
    check("b3_ch0", get_d(0, 0), 600);
    check("b3_ch1", get_d(0, 1), -15);
    check("b3_ovf", {60'd0, ovf0}, 0);
    check_all("b3");
    release_out();

    // Bubbles between beats do not count
    do_start(4);
    for (int k = 0; k < 7; k++) begin
      if (pat[k] != 0) rand_beat();
      else in_data = {$urandom, $urandom, $urandom};
      in_valid = (pat[k] != 0);
      check("bub_in_ready", {63'd0, in_ready0}, 1);
      check("bub_valid_early", {63'd0, out_valid0}, 0);
      tick();
      if (pat[k] != 0) model_add();
    end
    in_valid = 1'b0;
    check("bub_valid", {63'd0, out_valid0}, 1);
    check_all("bub");

    // HOLD stalls: data stable, input and start ignored
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom};
      start    = (k % 2 == 0);
      num_ops  = 9'd2;
      tick();
      check("hold_valid", {63'd0, out_valid0}, 1);
      check("hold_in_ready", {63'd0, in_ready0}, 0);
      check_all("hold");
    end
    in_valid = 1'b0;
    out_ready = 1'b1; start = 1'b1; num_ops = 9'd2;
    tick();
    out_ready = 1'b0; start = 1'b0;
    model_clear();
    check("b2b_in_ready", {63'd0, in_ready0}, 1);
    check("b2b_valid", {63'd0, out_valid0}, 0);
    check_all("b2b_clear");
    rand_beat(); send_beat();
    rand_beat(); send_beat();
    check("b2b_done", {63'd0, out_valid0}, 1);
    check_all("b2b");
    release_out();

    // Overflow: 8-bit saturate and wrap
    do_start(2);
    set_beat(100, -100, 0, 0); send_beat();
    set_beat(100, -100, 0, 0); send_beat();
    check("ovf_sat_ch0", get_d(1, 0), 127);
    check("ovf_sat_flag0", get_o(1, 0), 1);
    check("ovf_sat_ch1", get_d(1, 1), -128);
    check("ovf_wrap_ch0", get_d(2, 0), -56);
    check("ovf_wrap_flag0", get_o(2, 0), 1);
    check("ovf_wide_ch0", get_d(0, 0), 200);
    check("ovf_wide_flag0", get_o(0, 0), 0);
    check_all("ovf");
    out_ready = 1'b1; start = 1'b1; num_ops = 9'd0;
    tick();
    out_ready = 1'b0; start = 1'b0;
    check("hold_bad_cfg_err", {63'd0, cfg_err0}, 1);
    check("hold_bad_valid", {63'd0, out_valid0}, 0);
    check("hold_bad_in_ready", {63'd0, in_ready0}, 0);
    tick();
    check("hold_bad_cfg_err_pulse", {63'd0, cfg_err0}, 0);

    // Rejected operand counts, then the maximum
    start = 1'b1; num_ops = 9'd0;
    tick();
    start = 1'b0;
    check("cfg0_err", {63'd0, cfg_err0}, 1);
    check("cfg0_in_ready", {63'd0, in_ready0}, 0);
    tick();
    check("cfg0_pulse", {63'd0, cfg_err0}, 0);
    start = 1'b1; num_ops = 9'd289;
    tick();
    start = 1'b0;
    check("cfg289_err", {63'd0, cfg_err0}, 1);
    check("cfg289_in_ready", {63'd0, in_ready0}, 0);
    tick();
    check("cfg289_pulse", {63'd0, cfg_err0}, 0);
    check("cfg289_idle", {63'd0, in_ready0}, 0);
    do_start(288);
    check("max_cfg_err", {63'd0, cfg_err0}, 0);
    set_beat(1, 1, 1, 1);
    for (int k = 0; k < 288; k++) send_beat();
    check("max_valid", {63'd0, out_valid0}, 1);
    check("max_ch0", get_d(0, 0), 288);
    check_all("max");
    release_out();

    // Reset mid-accumulation discards everything
    do_start(5);
    rand_beat(); send_beat();
    rand_beat(); send_beat();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("abort_valid", {63'd0, out_valid0}, 0);
    check("abort_in_ready", {63'd0, in_ready0}, 0);
    check_all("abort");
    do_start(1);
    set_beat(7, 0, 0, 0); send_beat();
    check("abort_new_valid", {63'd0, out_valid0}, 1);
    check("abort_new_ch0", get_d(0, 0), 7);
    check_all("abort_new");
    release_out();

    // Randomised transactions with bubbles and output stalls
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 12);
      do_start(n);
      got = 0;
      guard = 0;
      while (got < n && guard < 200) begin
        v = $urandom_range(0, 1);
        if (v != 0) rand_beat();
        in_valid = (v != 0);
        tick();
        if (v != 0) begin
          model_add();
          got++;
        end
        guard++;
      end
      in_valid = 1'b0;
      check("rnd_valid", {63'd0, out_valid0}, 1);
      check_all($sformatf("rnd%0d", t));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        tick();
        check("rnd_stall_valid", {63'd0, out_valid0}, 1);
      end
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
